// File: rtl/uart_cmd_rx_pkg.sv
// Shared definitions for the uart command-frame receiver: FSM encoding and frame layout.
package uart_cmd_rx_pkg;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_ADDR,
        ST_DATA,
        ST_CSUM,
        ST_COMMIT
    } state_t;

    localparam logic [7:0] SYNC_DEF   = 8'hA5;
    localparam int         FRAME_LEN  = 7;
    // Payload bytes between ADDR and CSUM.
    localparam int         DATA_BYTES = FRAME_LEN - 3;

endpackage

// File: rtl/uart_cmd_rx_if.sv
// Byte stream from the uart rx FIFO plus the register-write bus into motion control.
interface uart_cmd_rx_if;

    logic        rx_empty;
    logic [7:0]  rx_data;
    logic        rx_read;
    logic        rx_oerr;
    logic        rx_ferr;
    logic        reg_we;
    logic [7:0]  reg_addr;
    logic [31:0] reg_data;

    // master: FIFO / register-space side; slave: the frame receiver.
    modport master (
        output rx_empty, rx_data, rx_oerr, rx_ferr,
        input  rx_read, reg_we, reg_addr, reg_data
    );

    modport slave (
        input  rx_empty, rx_data, rx_oerr, rx_ferr,
        output rx_read, reg_we, reg_addr, reg_data
    );

endinterface

// File: rtl/uart_cmd_rx_sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && !(&cnt))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/uart_cmd_rx.sv
// Assembles SYNC/ADDR/D0..D3/CSUM frames from the uart rx FIFO and issues one register write per good frame.
module uart_cmd_rx
    import uart_cmd_rx_pkg::*;
#(
    parameter logic [7:0] SYNC    = SYNC_DEF,
    parameter int         TIMEOUT = 50000,
    parameter int         CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    uart_cmd_rx_if.slave     bus,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] frame_ok_cnt,
    output logic [CNT_W-1:0] frame_err_cnt,
    output logic             busy
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    state_t            state_q, state_d;
    logic [7:0]        acc_q;
    logic [1:0]        idx_q;
    logic [7:0]        addr_sh;
    logic [31:0]       data_sh;
    logic [TMO_W-1:0]  tmo_q;
    logic              popped_q;
    logic              flag_abort, tmo_abort, pop;
    logic              ok_inc, err_inc;
    logic [7:0]        sum;

    always_comb begin
        flag_abort = (state_q != ST_HUNT) && (bus.rx_oerr || bus.rx_ferr);
        tmo_abort  = (state_q != ST_HUNT) && (tmo_q >= TMO_W'(TIMEOUT));
        // One pop every other cycle at most; any abort cause holds the byte for HUNT to see.
        pop        = reset && !bus.rx_empty && !popped_q && !flag_abort && !tmo_abort
                     && (state_q != ST_COMMIT);
        sum        = acc_q + bus.rx_data;
        state_d    = state_q;
        ok_inc     = 1'b0;
        err_inc    = 1'b0;
        if (flag_abort || tmo_abort) begin
            state_d = ST_HUNT;
            err_inc = 1'b1;
        end else begin
            case (state_q)
                ST_HUNT:   if (pop && bus.rx_data == SYNC) state_d = ST_ADDR;
                ST_ADDR:   if (pop) state_d = ST_DATA;
                ST_DATA:   if (pop && idx_q == 2'(DATA_BYTES - 1)) state_d = ST_CSUM;
                ST_CSUM: begin
                    if (pop) begin
                        if (sum == 8'h00) begin
                            state_d = ST_COMMIT;
                        end else begin
                            state_d = ST_HUNT;
                            err_inc = 1'b1;
                        end
                    end
                end
                ST_COMMIT: begin
                    state_d = ST_HUNT;
                    ok_inc  = 1'b1;
                end
                default:   state_d = ST_HUNT;
            endcase
        end
    end

    assign bus.rx_read = pop;
    assign busy        = (state_q != ST_HUNT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_HUNT;
            acc_q        <= '0;
            idx_q        <= '0;
            addr_sh      <= '0;
            data_sh      <= '0;
            tmo_q        <= '0;
            popped_q     <= 1'b0;
            bus.reg_we   <= 1'b0;
            bus.reg_addr <= '0;
            bus.reg_data <= '0;
        end else begin
            state_q    <= state_d;
            popped_q   <= pop;
            bus.reg_we <= ok_inc;
            tmo_q      <= (pop || state_q == ST_HUNT) ? '0 : tmo_q + 1'b1;
            if (pop) begin
                case (state_q)
                    ST_HUNT: acc_q <= '0;
                    ST_ADDR: begin
                        addr_sh <= bus.rx_data;
                        acc_q   <= sum;
                        idx_q   <= '0;
                    end
                    ST_DATA: begin
                        // Bytes arrive LSB first, so shift in from the top.
                        data_sh <= {bus.rx_data, data_sh[31:8]};
                        acc_q   <= sum;
                        idx_q   <= idx_q + 1'b1;
                    end
                    default: acc_q <= sum;
                endcase
            end
            if (ok_inc) begin
                bus.reg_addr <= addr_sh;
                bus.reg_data <= data_sh;
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_ok_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (ok_inc),
        .clr   (cnt_clr),
        .cnt   (frame_ok_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (err_inc),
        .clr   (cnt_clr),
        .cnt   (frame_err_cnt)
    );

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx: FIFO model feeding frames, register-write monitor, scenario tasks.
module tb_uart_cmd_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       cnt_clr;
    logic [1:0] frame_ok_cnt, frame_err_cnt;
    logic       busy;

    uart_cmd_rx_if bus ();

    uart_cmd_rx #(.TIMEOUT(100), .CNT_W(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .cnt_clr       (cnt_clr),
        .frame_ok_cnt  (frame_ok_cnt),
        .frame_err_cnt (frame_err_cnt),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int failed   = 0;

    // FWFT FIFO model: pops on rx_read sampled at the edge, head refreshed just after.
    logic [7:0] fifo[$];
    logic       rd_s;
    always begin
        @(posedge clk);
        rd_s = bus.rx_read;
        #1;
        if (rd_s === 1'b1 && fifo.size() > 0) void'(fifo.pop_front());
        bus.rx_empty = (fifo.size() == 0);
        bus.rx_data  = (fifo.size() > 0) ? fifo[0] : 8'h00;
    end

    // Monitor: register-write count, CSUM-pop to reg_we latency, back-to-back pops.
    int         cyc = 0, pop_cyc = 0, we_cnt = 0, we_lat = -1, consec = 0;
    logic       prev_rd = 1'b0;
    logic [7:0] we_addr;
    logic [31:0] we_data;
    always @(negedge clk) begin
        cyc++;
        if (bus.reg_we === 1'b1) begin
            we_cnt++;
            we_lat  = cyc - pop_cyc;
            we_addr = bus.reg_addr;
            we_data = bus.reg_data;
        end
        if (bus.rx_read === 1'b1) begin
            if (prev_rd) consec++;
            pop_cyc = cyc;
        end
        prev_rd = (bus.rx_read === 1'b1);
    end

    task automatic push_good();
        fifo.push_back(8'hA5); fifo.push_back(8'h10); fifo.push_back(8'h78);
        fifo.push_back(8'h56); fifo.push_back(8'h34); fifo.push_back(8'h12);
        fifo.push_back(8'hDC);
    endtask

    task automatic push_bad();
        fifo.push_back(8'hA5); fifo.push_back(8'h10); fifo.push_back(8'h78);
        fifo.push_back(8'h56); fifo.push_back(8'h34); fifo.push_back(8'h12);
        fifo.push_back(8'hDD);
    endtask

    task automatic clr_stats();
        @(negedge clk); cnt_clr = 1'b1;
        @(negedge clk); cnt_clr = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        @(negedge clk);
        while ((fifo.size() != 0 || busy !== 1'b0 || bus.rx_read !== 1'b0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        compared++;
        if (n >= 3000) begin
            failed++;
            $display("FAIL %s_idle: still busy after %0d cycles, required idle", nm, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; cnt_clr = 1'b0; bus.rx_oerr = 1'b0; bus.rx_ferr = 1'b0;
        repeat (3) @(negedge clk);
        compared++; if (bus.rx_read !== 1'b0) begin failed++; $display("FAIL rst_rx_read: got %b want 0", bus.rx_read); end
        compared++; if (bus.reg_we !== 1'b0) begin failed++; $display("FAIL rst_reg_we: got %b want 0", bus.reg_we); end
        compared++; if (bus.reg_addr !== 8'h00) begin failed++; $display("FAIL rst_reg_addr: got %h want 00", bus.reg_addr); end
        compared++; if (bus.reg_data !== 32'h0) begin failed++; $display("FAIL rst_reg_data: got %h want 0", bus.reg_data); end
        compared++; if (frame_ok_cnt !== 2'd0 || frame_err_cnt !== 2'd0) begin failed++; $display("FAIL rst_cnt: got %0d/%0d want 0/0", frame_ok_cnt, frame_err_cnt); end
        compared++; if (busy !== 1'b0) begin failed++; $display("FAIL rst_busy: got %b want 0", busy); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_good();
        int base = we_cnt;
        push_good();
        wait_idle("good");
        compared++; if (we_cnt - base !== 1) begin failed++; $display("FAIL good_we: got %0d writes want 1", we_cnt - base); end
        compared++; if (we_addr !== 8'h10) begin failed++; $display("FAIL good_addr: got %h want 10", we_addr); end
        compared++; if (we_data !== 32'h12345678) begin failed++; $display("FAIL good_data: got %h want 12345678", we_data); end
        compared++; if (we_lat !== 2) begin failed++; $display("FAIL good_latency: got %0d want 2", we_lat); end
        compared++; if (frame_ok_cnt !== 2'd1 || frame_err_cnt !== 2'd0) begin failed++; $display("FAIL good_cnt: got %0d/%0d want 1/0", frame_ok_cnt, frame_err_cnt); end
        compared++; if (consec !== 0) begin failed++; $display("FAIL good_pop_spacing: got %0d back-to-back pops want 0", consec); end
    endtask

    task automatic test_bad_csum();
        int base = we_cnt;
        clr_stats();
        push_bad();
        wait_idle("bad");
        compared++; if (we_cnt - base !== 0) begin failed++; $display("FAIL bad_we: got %0d writes want 0", we_cnt - base); end
        compared++; if (frame_err_cnt !== 2'd1 || frame_ok_cnt !== 2'd0) begin failed++; $display("FAIL bad_cnt: got ok %0d err %0d want 0/1", frame_ok_cnt, frame_err_cnt); end
        compared++; if (bus.reg_addr !== 8'h10 || bus.reg_data !== 32'h12345678) begin failed++; $display("FAIL bad_hold: got %h/%h want 10/12345678", bus.reg_addr, bus.reg_data); end
    endtask

    task automatic test_noise();
        int base = we_cnt;
        clr_stats();
        fifo.push_back(8'h00); fifo.push_back(8'hFF); fifo.push_back(8'h33);
        push_good();
        wait_idle("noise");
        compared++; if (we_cnt - base !== 1) begin failed++; $display("FAIL noise_we: got %0d writes want 1", we_cnt - base); end
        compared++; if (we_addr !== 8'h10 || we_data !== 32'h12345678) begin failed++; $display("FAIL noise_payload: got %h/%h want 10/12345678", we_addr, we_data); end
        compared++; if (frame_err_cnt !== 2'd0 || frame_ok_cnt !== 2'd1) begin failed++; $display("FAIL noise_cnt: got ok %0d err %0d want 1/0", frame_ok_cnt, frame_err_cnt); end
    endtask

    task automatic test_timeout();
        int base = we_cnt;
        clr_stats();
        fifo.push_back(8'hA5); fifo.push_back(8'h10); fifo.push_back(8'h78);
        wait_idle("tmo_stall");
        repeat (150) @(negedge clk);
        compared++; if (frame_err_cnt !== 2'd1) begin failed++; $display("FAIL tmo_err: got %0d want 1", frame_err_cnt); end
        compared++; if (busy !== 1'b0) begin failed++; $display("FAIL tmo_busy: got %b want 0", busy); end
        push_good();
        wait_idle("tmo_after");
        compared++; if (we_cnt - base !== 1 || frame_ok_cnt !== 2'd1) begin failed++; $display("FAIL tmo_recover: got %0d writes ok %0d want 1/1", we_cnt - base, frame_ok_cnt); end
    endtask

    task automatic test_flag();
        int base = we_cnt;
        int n = 0;
        clr_stats();
        fifo.push_back(8'hA5); fifo.push_back(8'h10); fifo.push_back(8'h78); fifo.push_back(8'h56);
        while (fifo.size() != 0 && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        bus.rx_ferr = 1'b1;
        @(negedge clk);
        bus.rx_ferr = 1'b0;
        fifo.push_back(8'h34); fifo.push_back(8'h12); fifo.push_back(8'hDC);
        wait_idle("flag");
        compared++; if (frame_err_cnt !== 2'd1) begin failed++; $display("FAIL flag_err: got %0d want 1", frame_err_cnt); end
        compared++; if (we_cnt - base !== 0 || frame_ok_cnt !== 2'd0) begin failed++; $display("FAIL flag_we: got %0d writes ok %0d want 0/0", we_cnt - base, frame_ok_cnt); end
    endtask

    task automatic test_reset_mid();
        int base = we_cnt;
        int n = 0;
        clr_stats();
        push_bad();
        fifo.push_back(8'hA5); fifo.push_back(8'h10); fifo.push_back(8'h78); fifo.push_back(8'h56);
        while (fifo.size() != 0 && n < 200) begin @(negedge clk); n++; end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        compared++; if (busy !== 1'b0 || bus.rx_read !== 1'b0 || bus.reg_we !== 1'b0) begin failed++; $display("FAIL rmid_ctrl: got busy %b rd %b we %b want 0/0/0", busy, bus.rx_read, bus.reg_we); end
        compared++; if (bus.reg_addr !== 8'h00 || bus.reg_data !== 32'h0) begin failed++; $display("FAIL rmid_regs: got %h/%h want 00/0", bus.reg_addr, bus.reg_data); end
        compared++; if (frame_err_cnt !== 2'd0 || frame_ok_cnt !== 2'd0) begin failed++; $display("FAIL rmid_cnt: got ok %0d err %0d want 0/0", frame_ok_cnt, frame_err_cnt); end
        reset = 1'b1;
        repeat (20) @(negedge clk);
        compared++; if (we_cnt - base !== 0) begin failed++; $display("FAIL rmid_we: got %0d writes want 0", we_cnt - base); end
    endtask

    task automatic test_saturation();
        clr_stats();
        for (int i = 0; i < 5; i++) push_bad();
        wait_idle("sat");
        compared++; if (frame_err_cnt !== 2'd3) begin failed++; $display("FAIL sat_err: got %0d want 3", frame_err_cnt); end
        clr_stats();
        @(negedge clk);
        compared++; if (frame_err_cnt !== 2'd0) begin failed++; $display("FAIL sat_clr: got %0d want 0", frame_err_cnt); end
        compared++; if (consec !== 0) begin failed++; $display("FAIL pop_spacing_total: got %0d back-to-back pops want 0", consec); end
    endtask

    initial begin
        test_reset();
        test_good();
        test_bad_csum();
        test_noise();
        test_timeout();
        test_flag();
        test_reset_mid();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule

// File: doc/uart_cmd_rx.md
Name: uart_cmd_rx

Overview:
Command-frame receiver sitting directly downstream of the uart receive FIFO. It drains bytes through the rx_empty/rx_read/rx_data interface and assembles fixed-length frames: sync, address, 32-bit data, checksum. Each valid frame is issued as a single-cycle register write into the motion-control register space. Invalid or interrupted frames are dropped and counted.

Parameters:
SYNC, 8'hA5, frame start byte
TIMEOUT, 50000, maximum clocks between bytes inside a frame before abort
CNT_W, 16, width of the frame statistics counters

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
rx_empty  in  1  uart rx FIFO empty; when 0, rx_data holds the head byte
rx_data  in  8  uart rx FIFO head byte (first-word-fall-through)
rx_read  out  1  one-cycle pop pulse to the uart rx FIFO
rx_oerr  in  1  uart overrun error flag
rx_ferr  in  1  uart framing error flag
reg_we  out  1  one-cycle register write strobe
reg_addr  out  8  write address, held until the next frame commits
reg_data  out  32  write data, held until the next frame commits
cnt_clr  in  1  synchronous clear of both counters
frame_ok_cnt  out  CNT_W  count of committed frames
frame_err_cnt  out  CNT_W  count of aborted frames
busy  out  1  high in any state other than HUNT

Behaviour:
- Reset values: rx_read=0, reg_we=0, reg_addr=0, reg_data=0, both counters 0, busy=0, state HUNT, byte index 0, checksum accumulator 0, timeout counter 0.
- Pop rule: when rx_empty=0 and no pop occurred in the previous cycle, assert rx_read for 1 cycle and consume rx_data in that same cycle. This gives at most one byte every 2 clocks, so a stale rx_empty is never acted on.
- Frame format: SYNC, ADDR, D0, D1, D2, D3, CSUM. D0 is the LSB, so reg_data = {D3,D2,D1,D0}. The frame is valid when (ADDR+D0+D1+D2+D3+CSUM) mod 256 == 0.
- States:
  - HUNT: a byte equal to SYNC moves to ADDR and clears the accumulator. Any other byte is discarded silently and is not counted.
  - ADDR: latch the address into a shadow register, add it to the accumulator, go to DATA with index 0.
  - DATA: shift the byte into the shadow data, add it to the accumulator, increment the index. After index 3 go to CSUM.
  - CSUM: add the byte. If the sum is 0, go to COMMIT. Otherwise increment frame_err_cnt and go to HUNT.
  - COMMIT: copy the shadows to reg_addr/reg_data, pulse reg_we for exactly 1 cycle, increment frame_ok_cnt, go to HUNT. reg_addr/reg_data are stable in the cycle reg_we=1 and remain stable afterwards.
- Latency: reg_we is asserted 2 clocks after the cycle in which the CSUM byte is popped.
- Shadow registers only: outputs never change on aborted frames.
- Timeout: the counter clears on every pop and increments each clock outside HUNT. Reaching TIMEOUT goes to HUNT and increments frame_err_cnt.
- Error flags: rx_oerr=1 or rx_ferr=1 outside HUNT goes to HUNT, increments frame_err_cnt (at most once per abort), and suppresses any pop that cycle. In HUNT the flags are ignored.
- Simultaneous abort causes (bad checksum, timeout, flag) in one cycle: a single abort with a single increment.
- A SYNC value appearing inside a frame is treated as ordinary data (no resync).
- Counters saturate at all-ones. cnt_clr has priority over an increment in the same cycle.
- Reset mid-frame: the partial frame is lost, no reg_we is issued, and the counters return to 0.

Decomposition:
- Shared package: state encoding constants (HUNT, ADDR, DATA, CSUM, COMMIT), the SYNC default, and the frame length constant 7.
- One natural sub-module: sat_counter (CNT_W, inc, clr), instantiated for frame_ok_cnt and frame_err_cnt.
- The FSM, pop logic and timeout live in the top block.

Test Plan:
1. Good frame: enqueue A5 10 78 56 34 12 DC.
   -> one reg_we with reg_addr=8'h10, reg_data=32'h12345678.
   -> frame_ok_cnt=1, frame_err_cnt=0.
   -> rx_read is never asserted on consecutive cycles.
2. Bad checksum: enqueue A5 10 78 56 34 12 DD.
   -> no reg_we; frame_err_cnt=1; reg_addr/reg_data remain unchanged from the prior frame.
3. Noise then frame: enqueue 00 FF 33 followed by the good frame from test 1.
   -> noise discarded; one reg_we (10/12345678); frame_err_cnt=0.
4. Timeout: with TIMEOUT=100, send A5 10 78 then stop for 150 clocks, then send the good frame.
   -> frame_err_cnt=1 after the stall; the following good frame commits normally.
5. Error flag: pulse rx_ferr for 1 cycle after D1 of a frame, then deliver the remaining bytes.
   -> abort with frame_err_cnt=1; the leftover bytes are hunted through; no reg_we.
6. Reset/saturation: assert reset mid-DATA.
   -> all outputs return to reset values.
   With CNT_W=2, send 5 bad frames.
   -> frame_err_cnt=3; cnt_clr then sets it to 0.
